// File: rtl/sipo_receiver.sv
//==============================================================================
// Module  : sipo_receiver
// Brief   : MSB-first serial-to-parallel word receiver with valid/ack output
//           register and sticky overrun flag.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sipo_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             start,
    input  logic             out_ack,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int                SR_W     = WIDTH - 1;
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    // The final bit is taken live from ser_in, so only WIDTH-1 bits are stored.
    logic [SR_W-1:0]   sr_q,        sr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [WIDTH-1:0]  d_out_q,     d_out_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q,   overrun_d;

    logic [WIDTH-1:0]  w_word;
    logic              w_complete;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        d_out_d     = d_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        w_word      = {sr_q, ser_in};
        w_complete  = 1'b0;

        if (out_valid_q && out_ack) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = SR_W'(ser_in);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = (sr_q << 1) | SR_W'(ser_in);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    w_complete = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An ack in the completing cycle frees the register for the new word.
        if (w_complete) begin
            if (!out_valid_q || out_ack) begin
                d_out_d     = w_word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign d_out     = d_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sipo_receiver.sv
//==============================================================================
// Module  : tb_sipo_receiver
// Brief   : Self-checking bench for sipo_receiver (WIDTH=4 and WIDTH=8).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sipo_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_in, start, out_ack;
    logic [3:0] d_out;
    logic       out_valid, busy, overrun;

    logic       ser8, start8, ack8;
    logic [7:0] d8;
    logic       v8, b8, ov8;

    always #5 clk = ~clk;

    sipo_receiver #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_in    (ser_in),
        .start     (start),
        .out_ack   (out_ack),
        .d_out     (d_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    sipo_receiver #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .ser_in    (ser8),
        .start     (start8),
        .out_ack   (ack8),
        .d_out     (d8),
        .out_valid (v8),
        .busy      (b8),
        .overrun   (ov8)
    );

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [3:0] word;
        logic [3:0] start_mask;   // bit i = start driven while bit i is on ser_in
        logic       ack_last;     // out_ack on the completing edge
        logic       post_ack;     // one ack cycle after completion
        logic [3:0] exp_d;
        logic       exp_ov;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send4(input logic [3:0] word, input logic [3:0] smask,
                         input logic ack_last, input exp_t e);
        exp_t got;
        for (int i = 0; i < 4; i++) begin
            ser_in  = word[3-i];
            start   = smask[i];
            out_ack = (i == 3) ? ack_last : 1'b0;
            if (i == 3) sb.push_back(e);
            tick();
            if (i < 3) check("busy_mid", busy, 1);
        end
        start   = 1'b0;
        out_ack = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            check("d_out", d_out, got.d);
            check("out_valid", out_valid, got.v);
            check("overrun", overrun, got.ov);
            check("busy_end", busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[6];
        exp_t       e;
        logic [7:0] w8;

        tbl[0] = '{4'b1011, 4'b0001, 1'b0, 1'b1, 4'b1011, 1'b0};
        tbl[1] = '{4'b0110, 4'b0001, 1'b0, 1'b0, 4'b0110, 1'b0};
        tbl[2] = '{4'b1001, 4'b0001, 1'b1, 1'b1, 4'b1001, 1'b0};
        tbl[3] = '{4'b1110, 4'b0111, 1'b0, 1'b1, 4'b1110, 1'b0};
        tbl[4] = '{4'b1100, 4'b0001, 1'b0, 1'b0, 4'b1100, 1'b0};
        tbl[5] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 4'b1100, 1'b1};

        reset = 1'b1;
        ser_in = 1'b0; start = 1'b0; out_ack = 1'b0;
        ser8 = 1'b0; start8 = 1'b0; ack8 = 1'b0;
        #1;
        check("rst_d_out", d_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst8_d_out", d8, 0);
        check("rst8_valid", v8, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);

        for (int r = 0; r < 6; r++) begin
            e = '{tbl[r].exp_d, 1'b1, tbl[r].exp_ov};
            send4(tbl[r].word, tbl[r].start_mask, tbl[r].ack_last, e);
            if (tbl[r].post_ack) begin
                out_ack = 1'b1;
                tick();
                out_ack = 1'b0;
                check("ack_valid", out_valid, 0);
                check("ack_d_hold", d_out, tbl[r].exp_d);
                check("ack_overrun", overrun, tbl[r].exp_ov);
            end
        end

        // Asynchronous reset mid-cycle with overrun set and d_out non-zero.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_d_out", d_out, 0);
        check("async_valid", out_valid, 0);
        check("async_overrun", overrun, 0);
        check("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_in = ~ser_in;
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", out_valid, 0);
        end

        // Reset after two bits of a frame; the partial word must vanish.
        ser_in = 1'b1; start = 1'b1;
        tick();
        ser_in = 1'b0; start = 1'b0;
        tick();
        check("partial_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_in = ~ser_in;
            tick();
            check("midrst_idle_busy", busy, 0);
            check("midrst_idle_valid", out_valid, 0);
        end
        e = '{4'b0101, 1'b1, 1'b0};
        send4(4'b0101, 4'b0001, 1'b0, e);

        // WIDTH=8 instance, 0xA5 MSB first.
        w8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            ser8   = w8[7-i];
            start8 = (i == 0);
            tick();
            if (i < 7) begin
                check("w8_valid_early", v8, 0);
                check("w8_busy", b8, 1);
            end
        end
        start8 = 1'b0;
        check("w8_d_out", d8, 8'hA5);
        check("w8_valid", v8, 1);
        check("w8_busy_end", b8, 0);
        check("w8_overrun", ov8, 0);
        ack8 = 1'b1;
        tick();
        ack8 = 1'b0;
        check("w8_ack_valid", v8, 0);
        check("w8_ack_d_hold", d8, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
